// File: rtl/ioctl_loader_pkg.sv
// rtl/ioctl_loader_pkg.sv - shared state codes and default timing for the ioctl loader
package ioctl_loader_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_XFER = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_TAIL = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  localparam int DEF_PRE_CYCLES  = 4;
  localparam int DEF_WR_GAP      = 2;
  localparam int DEF_POST_CYCLES = 4;

  localparam int TIMER_W = 16;
  localparam logic [24:0] ADDR_MAX = 25'h1FFFFFF;

endpackage

// File: rtl/ioctl_loader_timer.sv
// rtl/ioctl_loader_timer.sv - loadable down-counter that stops at zero and can be frozen
module ioctl_loader_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         freeze,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!freeze && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ioctl_loader.sv
// rtl/ioctl_loader.sv - streams source bytes into an ioctl-style download port with framing delays
module ioctl_loader
  import ioctl_loader_pkg::*;
#(
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int WR_GAP      = DEF_WR_GAP,
  parameter int POST_CYCLES = DEF_POST_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  start_index,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  input  logic        src_last,
  output logic        src_ready,
  input  logic        ioctl_wait,
  output logic        ioctl_download,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_index,
  output logic        busy,
  output logic        done,
  output logic [24:0] byte_count
);

  // Timer counts down to zero inclusive, so a window of N clocks loads N-1.
  // TAIL loads POST_CYCLES because its first clock carries the final strobe.
  localparam logic [TIMER_W-1:0] PRE_LOAD  = TIMER_W'((PRE_CYCLES > 0) ? PRE_CYCLES - 1 : 0);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [TIMER_W-1:0] POST_LOAD = TIMER_W'(POST_CYCLES);

  logic [1:0]         rst_sync;
  logic               run;
  logic [2:0]         state;
  logic               accept;
  logic               fire;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_freeze;
  logic               tmr_zero;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign src_ready  = (state == ST_XFER) && !ioctl_wait;
  assign fire       = src_valid && src_ready;
  assign accept     = (state == ST_IDLE) && start && run;
  assign tmr_load   = accept || fire;
  assign tmr_val    = accept ? PRE_LOAD : (src_last ? POST_LOAD : GAP_LOAD);
  assign tmr_freeze = ioctl_wait && (state == ST_GAP || state == ST_TAIL);

  ioctl_loader_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .freeze   (tmr_freeze),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state <= ST_ARM;
        ST_ARM:  if (tmr_zero) state <= ST_XFER;
        ST_XFER: begin
          if (fire) begin
            if (src_last)         state <= ST_TAIL;
            else if (WR_GAP == 0) state <= ST_XFER;
            else                  state <= ST_GAP;
          end
        end
        ST_GAP:  if (tmr_zero && !ioctl_wait) state <= ST_XFER;
        ST_TAIL: if (tmr_zero && !ioctl_wait) state <= ST_FIN;
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The address and count step at the end of each strobe, so the strobe carries the old address.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_wr    <= 1'b0;
      ioctl_dout  <= '0;
      ioctl_index <= '0;
      ioctl_addr  <= '0;
      byte_count  <= '0;
    end else begin
      ioctl_wr <= fire;
      if (fire) ioctl_dout <= src_data;
      if (accept) begin
        ioctl_index <= start_index;
        ioctl_addr  <= '0;
        byte_count  <= '0;
      end else if (ioctl_wr) begin
        ioctl_addr <= ioctl_addr + 25'd1;
        if (byte_count != ADDR_MAX) byte_count <= byte_count + 25'd1;
      end
    end
  end

  assign ioctl_download = (state == ST_ARM) || (state == ST_XFER) ||
                          (state == ST_GAP) || (state == ST_TAIL);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);

endmodule
